// File: rtl/sdram_arbiter.sv
// Two-port byte arbiter in front of the SDRAM controller: round-robin port grant,
// refresh pending counter with priority, one-cycle command pulses and ack handshake.
module sdram_arbiter #(
    parameter int REFRESH_CYCLES = 1600,
    parameter int ADDR_WIDTH     = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [7:0]            p0_wdata,
    output logic [7:0]            p0_rdata,
    output logic                  p0_ack,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [7:0]            p1_wdata,
    output logic [7:0]            p1_rdata,
    output logic                  p1_ack,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  mem_refresh,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_din,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_data_ready,
    input  logic                  mem_busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RECOVER} state_t;

    // The operation in flight, recorded at grant.
    typedef struct packed {
        logic port;
        logic we;
        logic refr;
    } op_t;

    state_t     state, state_nx;
    op_t        cur;
    logic [11:0] rcnt;
    logic [1:0] rpend;
    logic       last;
    logic       tick;
    logic       grant_ref, grant_port, gport, gwe, done;

    assign tick = (rcnt == 12'(REFRESH_CYCLES - 1));
    assign gwe  = gport ? p1_we : p0_we;

    always_comb begin
        state_nx   = state;
        grant_ref  = 1'b0;
        grant_port = 1'b0;
        gport      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (!mem_busy) begin
                    if (rpend != 2'd0) begin
                        grant_ref = 1'b1;
                        state_nx  = ISSUE;
                    end else if (p0_req || p1_req) begin
                        grant_port = 1'b1;
                        // On a tie the port that did not win last time goes next.
                        gport      = (p0_req && p1_req) ? ~last : p1_req;
                        state_nx   = ISSUE;
                    end
                end
            end
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: if (mem_busy) state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (!cur.refr && !cur.we) begin
                    if (mem_data_ready) begin
                        done     = 1'b1;
                        state_nx = RECOVER;
                    end
                end else if (!mem_busy) begin
                    done     = 1'b1;
                    state_nx = RECOVER;
                end
            end
            RECOVER:   state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= '0;
            rcnt        <= '0;
            rpend       <= '0;
            last        <= 1'b1;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            state <= state_nx;
            rcnt  <= tick ? 12'd0 : rcnt + 12'd1;
            // Simultaneous tick and issue cancel out.
            case ({tick, grant_ref})
                2'b10:   if (rpend != 2'd3) rpend <= rpend + 2'd1;
                2'b01:   rpend <= rpend - 2'd1;
                default: ;
            endcase
            mem_rd      <= grant_port && !gwe;
            mem_wr      <= grant_port && gwe;
            mem_refresh <= grant_ref;
            if (grant_ref)
                cur.refr <= 1'b1;
            if (grant_port) begin
                cur      <= '{port: gport, we: gwe, refr: 1'b0};
                last     <= gport;
                mem_addr <= gport ? p1_addr : p0_addr;
                mem_din  <= gport ? p1_wdata : p0_wdata;
            end
            p0_ack <= done && !cur.refr && !cur.port;
            p1_ack <= done && !cur.refr && cur.port;
            if (done && !cur.refr && !cur.we) begin
                if (cur.port) p1_rdata <= mem_dout;
                else          p0_rdata <= mem_dout;
            end
        end
    end

endmodule
